// File: rtl/gc_pkg.sv
// Shared definitions for the garbled-circuit evaluator: label/gate-id widths,
// colour-pair encodings and the evaluator FSM state type.
package gc_pkg;
  localparam int LABEL_W = 80;
  localparam int GID_W   = 64;

  localparam logic [1:0] C00 = 2'b00;
  localparam logic [1:0] C01 = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } eval_state_e;
endpackage

// File: rtl/garbled_core.sv
// Iterative SHA-1 over one padded block {kp, kq, gid}; one round per cycle,
// digest_80 is the top 80 bits of the 160-bit digest, pulsed with digest_valid.
import gc_pkg::*;

module garbled_core (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               kpq_valid,
  input  logic [LABEL_W-1:0] kp,
  input  logic [LABEL_W-1:0] kq,
  input  logic [GID_W-1:0]   gid,
  output logic               ready,
  output logic               digest_valid,
  output logic [LABEL_W-1:0] digest_80
);
  localparam logic [31:0] H0 = 32'h6745_2301;
  localparam logic [31:0] H1 = 32'hEFCD_AB89;
  localparam logic [31:0] H2 = 32'h98BA_DCFE;
  localparam logic [31:0] H3 = 32'h1032_5476;
  localparam logic [31:0] H4 = 32'hC3D2_E1F0;
  localparam int MSG_W     = 2 * LABEL_W + GID_W;
  localparam int MSG_WORDS = MSG_W / 32;

  logic               ready_r;
  logic               busy_r;
  logic               dv_r;
  logic [6:0]         round_r;
  logic [31:0]        w_r [16];
  logic [31:0]        a_r, b_r, c_r, d_r, e_r;
  logic [LABEL_W-1:0] digest_r;

  logic [MSG_W-1:0]   msg_s;
  logic [31:0]        f_s, k_s, temp_s, w_new_s, h2_s;
  logic               unused_s;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  assign msg_s    = {kp, kq, gid};
  assign h2_s     = H2 + rotl(b_r, 30);
  assign unused_s = ^h2_s[15:0];

  // Round function, schedule extension and working-variable update inputs
  always_comb begin
    f_s = 32'h0;
    k_s = 32'h0;
    if (round_r < 7'd20) begin
      f_s = (b_r & c_r) | (~b_r & d_r);
      k_s = 32'h5A82_7999;
    end else if (round_r < 7'd40) begin
      f_s = b_r ^ c_r ^ d_r;
      k_s = 32'h6ED9_EBA1;
    end else if (round_r < 7'd60) begin
      f_s = (b_r & c_r) | (b_r & d_r) | (c_r & d_r);
      k_s = 32'h8F1B_BCDC;
    end else begin
      f_s = b_r ^ c_r ^ d_r;
      k_s = 32'hCA62_C1D6;
    end
    temp_s  = rotl(a_r, 5) + f_s + e_r + k_s + w_r[0];
    w_new_s = rotl(w_r[13] ^ w_r[8] ^ w_r[2] ^ w_r[0], 1);
  end

  // Block load, 80 rounds with a sliding 16-word schedule window, digest output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      dv_r     <= 1'b0;
      round_r  <= 7'd0;
      digest_r <= '0;
      a_r <= 32'h0; b_r <= 32'h0; c_r <= 32'h0; d_r <= 32'h0; e_r <= 32'h0;
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
    end else begin
      dv_r <= 1'b0;
      if (busy_r) begin
        for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
        w_r[15] <= w_new_s;
        a_r <= temp_s;
        b_r <= a_r;
        c_r <= rotl(b_r, 30);
        d_r <= c_r;
        e_r <= d_r;
        round_r <= round_r + 7'd1;
        if (round_r == 7'd79) begin
          busy_r   <= 1'b0;
          dv_r     <= 1'b1;
          digest_r <= {H0 + temp_s, H1 + a_r, h2_s[31:16]};
        end
      end else if (kpq_valid && ready_r) begin
        for (int i = 0; i < MSG_WORDS; i++) w_r[i] <= msg_s[MSG_W-1-32*i -: 32];
        w_r[MSG_WORDS] <= 32'h8000_0000;
        for (int i = MSG_WORDS + 1; i < 15; i++) w_r[i] <= 32'h0;
        w_r[15] <= 32'(MSG_W);
        a_r <= H0; b_r <= H1; c_r <= H2; d_r <= H3; e_r <= H4;
        round_r <= 7'd0;
        busy_r  <= 1'b1;
        ready_r <= 1'b0;
      end else begin
        ready_r <= 1'b1;
      end
    end
  end

  assign ready        = ready_r;
  assign digest_valid = dv_r;
  assign digest_80    = digest_r;
endmodule

// File: rtl/evaluate_and.sv
// Evaluator-side AND gate: hashes the active input labels with the gate id and
// un-masks the 3-row reduced table row chosen by the colour bits to yield Wc.
import gc_pkg::*;

module evaluate_and #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LABEL_W-1:0] Wa,
  input  logic [LABEL_W-1:0] Wb,
  input  logic [GID_W-1:0]   g_id,
  input  logic [LABEL_W-1:0] T01,
  input  logic [LABEL_W-1:0] T10,
  input  logic [LABEL_W-1:0] T11,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] Wc,
  output logic [CNT_W-1:0]   gate_cnt,
  output logic               err
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  eval_state_e        state_r;
  logic [LABEL_W-1:0] wa_r, wb_r, t01_r, t10_r, t11_r, wc_r;
  logic [GID_W-1:0]   gid_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic               tmo_hit_r;
  logic               out_valid_r;
  logic [CNT_W-1:0]   gate_cnt_r;
  logic               err_r;

  logic               core_ready_s;
  logic               digest_valid_s;
  logic [LABEL_W-1:0] digest_s;
  logic [LABEL_W-1:0] wc_sel_s;
  logic               kpq_valid_s;

  assign kpq_valid_s = (state_r == ST_LAUNCH);
  assign in_ready    = (state_r == ST_IDLE) && core_ready_s;

  garbled_core u_core (
    .clk          (clk),
    .reset_n      (reset_n),
    .kpq_valid    (kpq_valid_s),
    .kp           (wa_r),
    .kq           (wb_r),
    .gid          (gid_r),
    .ready        (core_ready_s),
    .digest_valid (digest_valid_s),
    .digest_80    (digest_s)
  );

  // Row select by colour pair; colour 00 has no stored row
  always_comb begin
    case ({wa_r[0], wb_r[0]})
      C00:     wc_sel_s = digest_s;
      C01:     wc_sel_s = digest_s ^ t01_r;
      C10:     wc_sel_s = digest_s ^ t10_r;
      C11:     wc_sel_s = digest_s ^ t11_r;
      default: wc_sel_s = '0;
    endcase
  end

  // Gate FSM with input latches, timeout watchdog and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      wa_r <= '0; wb_r <= '0; gid_r <= '0;
      t01_r <= '0; t10_r <= '0; t11_r <= '0;
      wc_r        <= '0;
      out_valid_r <= 1'b0;
      gate_cnt_r  <= '0;
      err_r       <= 1'b0;
      tmo_cnt_r   <= '0;
      tmo_hit_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            wa_r  <= Wa;
            wb_r  <= Wb;
            gid_r <= g_id;
            t01_r <= T01;
            t10_r <= T10;
            t11_r <= T11;
            state_r <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt_r <= '0;
          tmo_hit_r <= 1'b0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (digest_valid_s) begin
            wc_r        <= wc_sel_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT)) begin
            // Hung core: report an all-zero label and drop the bundle
            err_r       <= 1'b1;
            tmo_hit_r   <= 1'b1;
            wc_r        <= '0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (!tmo_hit_r) gate_cnt_r <= gate_cnt_r + CNT_W'(1);
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign Wc        = wc_r;
  assign gate_cnt  = gate_cnt_r;
  assign err       = err_r;
endmodule
